uart_report_scheduler: RTL

Sequences the shared UART transmitter so the game can report events to a host terminal. Three event sources request messages: game start, score change and game over. The block arbitrates between them and formats each message as ASCII. It then streams the message byte by byte through the uart_tx start/busy handshake. It sits between game_fsm/score_counter and uart_tx in top_whackamole, and drives tx_start and tx_data.

---
 rtl/uart_report_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_report_scheduler.sv
// uart_report_scheduler: arbitrates game event reports and streams them as ASCII through uart_tx
module uart_report_scheduler #(
  parameter int ACK_TIMEOUT   = 16,
  parameter bit SCORE_REPORTS = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_event,
  input  logic       score_event,
  input  logic       over_event,
  input  logic [5:0] score,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       report_active,
  output logic       ack_error
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;
  typedef enum logic [1:0] {M_START, M_SCORE, M_OVER} msg_t;
  state_t state;
  msg_t msg, sel_msg;
  logic p_start, p_score, p_over, sel;
  logic [2:0] idx, last;
  logic [3:0] tens, ones;
  logic [7:0] cur;
  logic [CW-1:0] cnt;
  // Fixed-priority pick among pending reports, current message byte and its length
  always_comb begin
    sel     = state == IDLE && (p_start || p_score || p_over);
    sel_msg = p_over ? M_OVER : p_start ? M_START : M_SCORE;
    last    = msg == M_START ? 3'd3 : msg == M_SCORE ? 3'd5 : 3'd6;
    cur     = 8'h0A;
    case (msg)
      M_START: cur = idx == 3'd0 ? 8'h47 : idx == 3'd1 ? 8'h53 : idx == 3'd2 ? 8'h0D : 8'h0A;
      M_SCORE: cur = idx == 3'd0 ? 8'h53 : idx == 3'd1 ? 8'h3D : idx == 3'd2 ? {4'h3, tens} :
                     idx == 3'd3 ? {4'h3, ones} : idx == 3'd4 ? 8'h0D : 8'h0A;
      default: cur = idx == 3'd0 ? 8'h47 : idx == 3'd1 ? 8'h4F : idx == 3'd2 ? 8'h20 :
                     idx == 3'd3 ? {4'h3, tens} : idx == 3'd4 ? {4'h3, ones} :
                     idx == 3'd5 ? 8'h0D : 8'h0A;
    endcase
  end
  // Pending flags: set by events, cleared on selection; a new game discards any stale score report
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_start <= 1'b0;
      p_score <= 1'b0;
      p_over  <= 1'b0;
    end else begin
      p_over  <= over_event || (p_over && !sel);
      p_start <= start_event || (p_start && !(sel && !p_over));
      p_score <= SCORE_REPORTS && !start_event &&
                 (score_event || (p_score && !(sel && !p_over && !p_start)));
    end
  end
  // Message sequencer: one byte per start/busy handshake, with a bounded wait for busy to rise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      msg           <= M_START;
      idx           <= 3'd0;
      tens          <= 4'd0;
      ones          <= 4'd0;
      cnt           <= '0;
      tx_start      <= 1'b0;
      tx_data       <= 8'h00;
      report_active <= 1'b0;
      ack_error     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          report_active <= sel;
          if (sel) begin
            msg   <= sel_msg;
            idx   <= 3'd0;
            tens  <= 4'(score / 6'd10);
            ones  <= 4'(score % 6'd10);
            state <= SEND;
          end
        end
        SEND: begin
          tx_data <= cur;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
          else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            ack_error <= 1'b1;
            state     <= NEXT;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_LO: if (!tx_busy) state <= NEXT;
        NEXT: begin
          if (idx == last) begin
            report_active <= 1'b0;
            state         <= IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
